uart_tx_arbiter: RTL and testbench

- Shares one byte-wide UART transmitter among NUM_REQ requesters. Requesters include the reset-triggered greeting source, a status reporter and a debug echo.
- Arbitration is round-robin. One grant may cover a multi-byte burst, so a message is never interleaved with another.
- Sits between the requesters and the UART TX datapath, in the 12 MHz system clock domain.
- Drives the transmitter through a start/busy/done byte handshake.

---
 rtl/uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter in front of a shared UART transmitter
// Optional tx_done watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 16,
  parameter int HOLD_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 1300000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 grant_valid,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, HOLD} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic [9:0]         hold_cnt_q, hold_cnt_d;
  logic               last_q, last_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic               release_grant;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == LAUNCH && !tx_busy) req_ready = grant_q & req_valid;
  end

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    gidx_d        = gidx_q;
    last_grant_d  = last_grant_q;
    byte_cnt_d    = byte_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    last_d        = last_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    release_grant = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          grant_valid_d = 1'b1;
          gidx_d        = pick_idx;
          byte_cnt_d    = 8'd0;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        if (sel_valid && !tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = sel_data;
          last_d     = sel_last;
          byte_cnt_d = byte_cnt_q + 8'd1;
          state_d    = SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      SEND: begin
        if (tx_done) begin
          if (last_q || byte_cnt_q == 8'(MAX_BURST)) begin
            release_grant = 1'b1;
          end else begin
            hold_cnt_d = 10'd0;
            state_d    = HOLD;
          end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          release_grant = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
      end
      HOLD: begin
        if (sel_valid) begin
          state_d = LAUNCH;
        end else if (hold_cnt_q == 10'(HOLD_CYCLES - 1)) begin
          release_grant = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (release_grant) begin
      last_grant_d  = gidx_q;
      grant_d       = '0;
      grant_valid_d = 1'b0;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      gidx_q        <= '0;
      last_grant_q  <= IW'(NUM_REQ - 1);
      byte_cnt_q    <= 8'd0;
      hold_cnt_q    <= 10'd0;
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      gidx_q        <= gidx_d;
      last_grant_q  <= last_grant_d;
      byte_cnt_q    <= byte_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        grant_valid, tx_start, tx_busy, tx_done;
  logic [7:0]  tx_data;

  logic [3:0]  req_valid_b, req_last_b, req_ready_b, grant_b;
  logic [31:0] req_data_b;
  logic        grant_valid_b, tx_start_b, tx_busy_b, tx_done_b;
  logic [7:0]  tx_data_b;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic        timeout_err, timeout_err_b;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .grant_valid(grant_valid),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
`ifdef UART_TX_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(2), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(10)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_data(req_data_b), .req_last(req_last_b),
    .req_ready(req_ready_b), .grant(grant_b), .grant_valid(grant_valid_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
`ifdef UART_TX_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err_b)
`endif
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete single-byte message from IDLE back to IDLE.
  task automatic serve(input string tag, input logic [3:0] g, input logic [7:0] d);
    tick();
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_ready"}, 32'(req_ready), 32'(g));
    tick();
    chk({tag, "_start"}, 32'(tx_start), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(d));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk({tag, "_release"}, 32'(grant), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    req_valid_b = '0; req_last_b = '0; req_data_b = '0; tx_busy_b = 1'b0; tx_done_b = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_b", 32'(grant_b), 32'd0);
    reset = 1'b0;

    // single byte from requester 0
    req_valid = 4'b0001; req_data[7:0] = 8'h77; req_last = 4'b0001;
    #1 chk("single_idle_ready", 32'(req_ready), 32'd0);
    tick();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_grant_valid", 32'(grant_valid), 32'd1);
    chk("single_no_start_yet", 32'(tx_start), 32'd0);
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    chk("single_start", 32'(tx_start), 32'd1);
    chk("single_data", 32'(tx_data), 32'h77);
    chk("single_send_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    tick();
    chk("single_start_pulse", 32'(tx_start), 32'd0);
    chk("single_send_grant", 32'(grant), 32'h1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("single_release", 32'(grant), 32'd0);
    chk("single_release_valid", 32'(grant_valid), 32'd0);

    // round robin; last owner was 0 so requester 1 goes first
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'hA3A2A1A0;
    serve("rr1", 4'b0010, 8'hA1);
    serve("rr2", 4'b0100, 8'hA2);
    serve("rr3", 4'b1000, 8'hA3);
    serve("rr4", 4'b0001, 8'hA0);
    serve("rr5", 4'b0010, 8'hA1);
    req_valid = 4'b0000;

    // burst lock: requester 2 owns the link for three bytes while 1 waits
    req_valid = 4'b0110; req_last = 4'b0010; req_data = 32'h0041_5500;
    tick();
    chk("burst_grant", 32'(grant), 32'h4);
    chk("burst_ready", 32'(req_ready), 32'h4);
    tick();
    chk("burst_b1", 32'(tx_data), 32'h41);
    req_data[23:16] = 8'h42; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("burst_hold1_grant", 32'(grant), 32'h4);
    chk("burst_hold1_ready", 32'(req_ready), 32'd0);
    tick();
    chk("burst_relaunch", 32'(req_ready), 32'h4);
    tick();
    chk("burst_b2", 32'(tx_data), 32'h42);
    req_data[23:16] = 8'h43; req_last = 4'b0110; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("burst_hold2_grant", 32'(grant), 32'h4);
    tick();
    tick();
    chk("burst_b3", 32'(tx_data), 32'h43);
    req_valid = 4'b0010; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("burst_release", 32'(grant), 32'd0);
    tick();
    chk("burst_next_grant", 32'(grant), 32'h2);
    tick();
    chk("burst_next_data", 32'(tx_data), 32'h55);
    req_valid = 4'b0000; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("burst_next_release", 32'(grant), 32'd0);

    // busy stall, then reset while in SEND
    req_valid = 4'b0001; req_data[7:0] = 8'h5A; req_last = 4'b0001; tx_busy = 1'b1;
    tick();
    chk("busy_grant", 32'(grant), 32'h1);
    chk("busy_ready0", 32'(req_ready), 32'd0);
    tick();
    chk("busy_no_start", 32'(tx_start), 32'd0);
    chk("busy_ready1", 32'(req_ready), 32'd0);
    tx_busy = 1'b0;
    #1 chk("busy_fall_ready", 32'(req_ready), 32'h1);
    tick();
    chk("busy_start", 32'(tx_start), 32'd1);
    chk("busy_data", 32'(tx_data), 32'h5A);
    req_valid = 4'b0011; tx_busy = 1'b1;
    tick();
    chk("send_grant", 32'(grant), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0; tx_busy = 1'b0;
    tick();
    chk("post_rst_grant", 32'(grant), 32'h1);
    req_valid = 4'b0000;

    // MAX_BURST=2: requester 0 never marks last
    req_valid_b = 4'b0001; req_data_b[7:0] = 8'h11; req_last_b = 4'b0000;
    tick();
    chk("lim_grant", 32'(grant_b), 32'h1);
    tick();
    chk("lim_b1", 32'(tx_data_b), 32'h11);
    req_data_b[7:0] = 8'h12; tx_done_b = 1'b1;
    tick();
    tx_done_b = 1'b0;
    chk("lim_hold_grant", 32'(grant_b), 32'h1);
    tick();
    tick();
    chk("lim_b2", 32'(tx_data_b), 32'h12);
    tx_done_b = 1'b1;
    tick();
    tx_done_b = 1'b0;
    chk("lim_forced_release", 32'(grant_b), 32'd0);
    chk("lim_forced_release_valid", 32'(grant_valid_b), 32'd0);

    // HOLD_CYCLES=4: requester 0 goes quiet mid-burst, requester 1 must wait
    tick();
    chk("hold_grant", 32'(grant_b), 32'h1);
    tick();
    chk("hold_b1", 32'(tx_data_b), 32'h12);
    req_valid_b = 4'b0010; req_data_b[15:8] = 8'h99; req_last_b = 4'b0010; tx_done_b = 1'b1;
    tick();
    tx_done_b = 1'b0;
    chk("hold_c1", 32'(grant_b), 32'h1);
    tick();
    chk("hold_c2", 32'(grant_b), 32'h1);
    tick();
    chk("hold_c3", 32'(grant_b), 32'h1);
    tick();
    chk("hold_c4", 32'(grant_b), 32'h1);
    tick();
    chk("hold_release", 32'(grant_b), 32'd0);
    tick();
    chk("hold_next_grant", 32'(grant_b), 32'h2);

`ifdef UART_TX_ARB_TIMEOUT_EN
    tick();
    chk("to_start", 32'(tx_start_b), 32'd1);
    req_valid_b = 4'b0000;
    for (int i = 0; i < 9; i++) tick();
    chk("to_not_yet", 32'(timeout_err_b), 32'd0);
    chk("to_still_granted", 32'(grant_b), 32'h2);
    tick();
    chk("to_pulse", 32'(timeout_err_b), 32'd1);
    chk("to_release", 32'(grant_b), 32'd0);
    tick();
    chk("to_pulse_end", 32'(timeout_err_b), 32'd0);
    tx_done_b = 1'b1;
    tick();
    tx_done_b = 1'b0;
    chk("to_stray_grant", 32'(grant_b), 32'd0);
    chk("to_stray_start", 32'(tx_start_b), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
